// File: rtl/sdram_wrqueue.sv
// Write-side queue in front of the SDRAM/VGA controller: buffers host pixel
// writes and fill-engine words, then issues them one strobe at a time under the lock handshake.
module sdram_wrqueue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [21:0]           wr_address,
    input  logic [15:0]           wr_data,
    input  logic                  fill_start,
    input  logic [21:0]           fill_base,
    input  logic [15:0]           fill_len,
    input  logic [15:0]           fill_color,
    output logic                  fill_busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic [21:0]           sd_address,
    output logic [15:0]           sd_data,
    output logic                  sd_rdwr,
    output logic                  sd_clk,
    input  logic                  sd_lock
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WORD_W = 38;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SENT,
        S_BUSY
    } state_t;

    // FIFO storage and pointers
    logic [WORD_W-1:0]      mem_q [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   full, empty;

    // fill engine
    logic                   fill_busy_q, fill_busy_d;
    logic [21:0]            fill_addr_q, fill_addr_d;
    logic [15:0]            fill_rem_q, fill_rem_d;
    logic [15:0]            fill_color_q, fill_color_d;

    // drain FSM and controller-facing registers
    state_t                 state_q, state_d;
    logic                   sd_clk_q, sd_clk_d;
    logic [21:0]            sd_address_q;
    logic [15:0]            sd_data_q;

    logic                   host_push, fill_push, push, pop, load;
    logic                   fill_accept;
    logic [WORD_W-1:0]      push_word;

    // count tops out at DEPTH, so its MSB alone marks full
    assign full  = count_q[DEPTH_LOG2];
    assign empty = (count_q == '0);

    assign wr_ready  = !full && !fill_busy_q;
    assign fill_busy = fill_busy_q;
    assign level     = count_q;
    assign sd_clk    = sd_clk_q;
    assign sd_address = sd_address_q;
    assign sd_data   = sd_data_q;
    assign sd_rdwr   = 1'b1;

    // host and fill pushes are exclusive because wr_ready is low while the fill runs
    assign host_push = wr_valid && wr_ready;
    assign fill_push = fill_busy_q && !full;
    assign push      = host_push || fill_push;
    assign push_word = fill_push ? {fill_addr_q, fill_color_q} : {wr_address, wr_data};
    assign fill_accept = fill_start && !fill_busy_q && (fill_len != 16'd0);

    always_comb begin
        fill_busy_d  = fill_busy_q;
        fill_addr_d  = fill_addr_q;
        fill_rem_d   = fill_rem_q;
        fill_color_d = fill_color_q;
        if (fill_accept) begin
            fill_busy_d  = 1'b1;
            fill_addr_d  = fill_base;
            fill_rem_d   = fill_len;
            fill_color_d = fill_color;
        end else if (fill_push) begin
            fill_addr_d = fill_addr_q + 22'd1;
            fill_rem_d  = fill_rem_q - 16'd1;
            if (fill_rem_q == 16'd1) begin
                fill_busy_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sd_clk_d = 1'b0;
        load     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !sd_lock) begin
                    load     = 1'b1;
                    sd_clk_d = 1'b1;
                    state_d  = S_SENT;
                end
            end
            // the controller only raises lock on the strobe edge, so it is not valid yet here
            S_SENT: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (!sd_lock) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // the head is read straight into the controller-facing registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sd_address_q <= '0;
            sd_data_q    <= '0;
        end else if (load) begin
            {sd_address_q, sd_data_q} <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sd_clk_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fill_busy_q  <= 1'b0;
            fill_addr_q  <= '0;
            fill_rem_q   <= '0;
            fill_color_q <= '0;
        end else begin
            state_q      <= state_d;
            sd_clk_q     <= sd_clk_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fill_busy_q  <= fill_busy_d;
            fill_addr_q  <= fill_addr_d;
            fill_rem_q   <= fill_rem_d;
            fill_color_q <= fill_color_d;
        end
    end

endmodule

// File: tb/tb_sdram_wrqueue.sv
// Bench for sdram_wrqueue: a lock-raising controller model checks every strobe
// against an in-order queue of expected {address, data} words.
module tb_sdram_wrqueue;

    localparam int DL = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [21:0]       wr_address = '0;
    logic [15:0]       wr_data = '0;
    logic              fill_start = 1'b0;
    logic [21:0]       fill_base = '0;
    logic [15:0]       fill_len = '0;
    logic [15:0]       fill_color = '0;
    logic              fill_busy;
    logic [DL:0]       level;
    logic [21:0]       sd_address;
    logic [15:0]       sd_data;
    logic              sd_rdwr;
    logic              sd_clk;
    logic              sd_lock;

    int                tests_run = 0;
    int                tests_failed = 0;
    logic [37:0]       exp_q[$];
    int                lock_cnt = 0;
    int                lock_len = 9;
    bit                lock_rand = 1'b0;
    bit                force_lock = 1'b0;
    bit                track = 1'b0;
    logic [37:0]       last_word = '0;
    int                strobe_cnt = 0;

    sdram_wrqueue #(.DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_address(wr_address), .wr_data(wr_data),
        .fill_start(fill_start), .fill_base(fill_base),
        .fill_len(fill_len), .fill_color(fill_color),
        .fill_busy(fill_busy), .level(level),
        .sd_address(sd_address), .sd_data(sd_data),
        .sd_rdwr(sd_rdwr), .sd_clk(sd_clk), .sd_lock(sd_lock)
    );

    always #5 clock = ~clock;

    assign sd_lock = force_lock || (lock_cnt > 0);

    // Controller model: each strobe is checked in order, then lock is held while the write runs.
    always @(negedge clock) begin
        if (sd_clk === 1'b1) begin
            strobe_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL strobe_unexpected: got addr=%h data=%h, required no strobe", sd_address, sd_data);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({sd_address, sd_data} !== e)  begin
                    tests_failed++;
                    $display("FAIL strobe_order: got addr=%h data=%h, required addr=%h data=%h",
                             sd_address, sd_data, e[37:16], e[15:0]);
                end else begin
                    $display("[TB] strobe addr=%h data=%h", sd_address, sd_data);
                end
            end
            last_word = {sd_address, sd_data};
            track = 1'b1;
            lock_cnt = lock_rand ? int'($urandom_range(1, 12)) : lock_len;
        end else if (lock_cnt > 0) begin
            if (track) begin
                tests_run++;
                if ({sd_address, sd_data} !== last_word) begin
                    tests_failed++;
                    $display("FAIL hold_during_lock: got %h, required %h", {sd_address, sd_data}, last_word);
                end
            end
            lock_cnt--;
        end
    end

    task automatic host_write(input logic [21:0] a, input logic [15:0] d);
        int t;
        t = 0;
        wr_valid = 1'b1;
        wr_address = a;
        wr_data = d;
        while (wr_ready !== 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL host_accept: addr=%h wr_ready=%b, required 1", a, wr_ready);
        end else begin
            exp_q.push_back({a, d});
        end
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || level !== '0 || lock_cnt != 0) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        tests_run++;
        if (t >= 3000) begin
            tests_failed++;
            $display("FAIL drain: pending=%0d level=%0d, required 0 and 0", exp_q.size(), level);
        end
    endtask

    task automatic wait_fill_idle();
        int t;
        t = 0;
        while (fill_busy !== 1'b0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        tests_run++;
        if (fill_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_finish: fill_busy=%b, required 0", fill_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tests_run += 6;
        if (sd_clk !== 1'b0)     begin tests_failed++; $display("FAIL reset_sd_clk: got %b, required 0", sd_clk); end
        if (wr_ready !== 1'b1)   begin tests_failed++; $display("FAIL reset_wr_ready: got %b, required 1", wr_ready); end
        if (level !== '0)        begin tests_failed++; $display("FAIL reset_level: got %0d, required 0", level); end
        if (fill_busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_fill_busy: got %b, required 0", fill_busy); end
        if ({sd_address, sd_data} !== 38'd0) begin tests_failed++; $display("FAIL reset_sd_bus: got %h, required 0", {sd_address, sd_data}); end
        if (sd_rdwr !== 1'b1)    begin tests_failed++; $display("FAIL reset_rdwr: got %b, required 1", sd_rdwr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests_run++;
            if (sd_clk !== 1'b0) begin tests_failed++; $display("FAIL idle_sd_clk: got %b, required 0", sd_clk); end
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        lock_len = 9;
        lock_rand = 1'b0;
        host_write(22'h00012A, 16'hF800);
        tests_run++;
        if (level !== 5'd1) begin tests_failed++; $display("FAIL single_level_push: got %0d, required 1", level); end
        @(negedge clock);
        tests_run++;
        if (sd_clk !== 1'b1 || sd_address !== 22'h00012A || sd_data !== 16'hF800) begin
            tests_failed++;
            $display("FAIL single_strobe: got clk=%b addr=%h data=%h, required 1 00012a f800", sd_clk, sd_address, sd_data);
        end
        @(negedge clock);
        tests_run++;
        if (sd_clk !== 1'b0 || level !== 5'd1) begin
            tests_failed++;
            $display("FAIL single_after_strobe: got clk=%b level=%0d, required 0 and 1", sd_clk, level);
        end
        wait_drain();
        tests_run++;
        if (sd_address !== 22'h00012A) begin tests_failed++; $display("FAIL single_addr_hold: got %h, required 00012a", sd_address); end
    endtask

    task automatic test_lock_full();
        logic [21:0] a [20];
        logic [15:0] d [20];
        int acc;
        int t;
        for (int i = 0; i < 20; i++) begin
            a[i] = 22'($urandom);
            d[i] = 16'($urandom);
        end
        lock_len = 9;
        force_lock = 1'b1;
        @(negedge clock);
        acc = 0;
        for (int c = 0; c < 100; c++) begin
            if (acc < 20) begin
                wr_valid = 1'b1;
                wr_address = a[acc];
                wr_data = d[acc];
                if (wr_ready === 1'b1) begin
                    exp_q.push_back({a[acc], d[acc]});
                    acc++;
                end
            end
            @(negedge clock);
        end
        tests_run += 3;
        if (acc != 16)           begin tests_failed++; $display("FAIL full_accepted: got %0d, required 16", acc); end
        if (level !== 5'd16)     begin tests_failed++; $display("FAIL full_level: got %0d, required 16", level); end
        if (wr_ready !== 1'b0)   begin tests_failed++; $display("FAIL full_wr_ready: got %b, required 0", wr_ready); end
        force_lock = 1'b0;
        t = 0;
        while (acc < 20 && t < 400) begin
            wr_valid = 1'b1;
            wr_address = a[acc];
            wr_data = d[acc];
            if (wr_ready === 1'b1) begin
                exp_q.push_back({a[acc], d[acc]});
                acc++;
            end
            @(negedge clock);
            t++;
        end
        wr_valid = 1'b0;
        tests_run++;
        if (acc != 20) begin tests_failed++; $display("FAIL full_remaining: got %0d, required 20", acc); end
        wait_drain();
        $display("[TB] lock-full scenario: %0d writes accepted", acc);
    endtask

    task automatic test_fill_wrap();
        lock_len = 9;
        fill_start = 1'b1;
        fill_base = 22'h3FFFFE;
        fill_len = 16'd4;
        fill_color = 16'h07E0;
        for (int i = 0; i < 4; i++) exp_q.push_back({22'(22'h3FFFFE + i), 16'h07E0});
        @(negedge clock);
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (fill_busy !== 1'b1 || wr_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL fill_busy_window[%0d]: got busy=%b ready=%b, required 1 and 0", i, fill_busy, wr_ready);
            end
            @(negedge clock);
        end
        tests_run++;
        if (fill_busy !== 1'b0 || level !== 5'd4) begin
            tests_failed++;
            $display("FAIL fill_end: got busy=%b level=%0d, required 0 and 4", fill_busy, level);
        end
        wait_drain();
    endtask

    task automatic test_fill_arbitration();
        fill_start = 1'b1;
        fill_len = 16'd0;
        fill_base = 22'h000100;
        @(negedge clock);
        fill_start = 1'b0;
        tests_run++;
        if (fill_busy !== 1'b0 || level !== '0) begin
            tests_failed++;
            $display("FAIL fill_zero_len: got busy=%b level=%0d, required 0 and 0", fill_busy, level);
        end
        tests_run++;
        if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL arb_ready: got %b, required 1", wr_ready); end
        wr_valid = 1'b1;
        wr_address = 22'h2A5A5A;
        wr_data = 16'h1234;
        fill_start = 1'b1;
        fill_base = 22'h001000;
        fill_len = 16'd5;
        fill_color = 16'h001F;
        exp_q.push_back({22'h2A5A5A, 16'h1234});
        for (int i = 0; i < 5; i++) exp_q.push_back({22'(22'h001000 + i), 16'h001F});
        @(negedge clock);
        wr_valid = 1'b0;
        fill_base = 22'h0ABCDE;
        fill_len = 16'd7;
        fill_color = 16'hFFFF;
        tests_run++;
        if (fill_busy !== 1'b1) begin tests_failed++; $display("FAIL arb_busy: got %b, required 1", fill_busy); end
        @(negedge clock);
        fill_start = 1'b0;
        wait_fill_idle();
        wait_drain();
    endtask

    task automatic test_random();
        lock_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                logic [21:0] b;
                logic [15:0] l;
                logic [15:0] c;
                b = 22'($urandom);
                l = 16'($urandom_range(0, 8));
                c = 16'($urandom);
                fill_start = 1'b1;
                fill_base = b;
                fill_len = l;
                fill_color = c;
                for (int i = 0; i < int'(l); i++) exp_q.push_back({22'(b + 22'(i)), c});
                @(negedge clock);
                fill_start = 1'b0;
                wait_fill_idle();
            end else begin
                host_write(22'($urandom), 16'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_drain();
        lock_rand = 1'b0;
        $display("[TB] random scenario done, strobes so far=%0d", strobe_cnt);
    endtask

    task automatic test_reset_busy();
        int s0;
        lock_len = 9;
        for (int i = 0; i < 5; i++) host_write(22'(22'h000200 + i), 16'(16'hA000 + i));
        tests_run++;
        if (level !== 5'd5) begin tests_failed++; $display("FAIL rst_busy_level_before: got %0d, required 5", level); end
        reset = 1'b1;
        track = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (level !== '0 || sd_clk !== 1'b0 || fill_busy !== 1'b0 || wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_busy_after: got level=%0d clk=%b busy=%b ready=%b, required 0 0 0 1",
                     level, sd_clk, fill_busy, wr_ready);
        end
        s0 = strobe_cnt;
        repeat (30) @(negedge clock);
        tests_run++;
        if (strobe_cnt != s0) begin tests_failed++; $display("FAIL rst_busy_quiet: got %0d strobes, required 0", strobe_cnt - s0); end
        host_write(22'h1FFFFF, 16'hBEEF);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_lock_full();
        test_fill_wrap();
        test_fill_arbitration();
        test_random();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_wrqueue.md
Name: sdram_wrqueue

Overview:
- Write-side client placed directly upstream of the SDRAM/VGA 640x480 controller.
- Buffers host pixel writes (22-bit word address, 16-bit RGB565 data) in a FIFO.
- Drains the FIFO into the controller's single-write interface (address / i_data / rdwr / clk / lock), obeying the controller's lock handshake.
- Also contains a hardware fill engine that streams a constant colour into a linear address range, e.g. to clear the framebuffer.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries of {address[21:0], data[15:0]}.

Ports:
- clock  in  1  100 MHz system clock; the same clock that drives the SDRAM controller.
- reset  in  1  synchronous reset, active-high.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted in a cycle where wr_valid & wr_ready.
- wr_address  in  22  host word address.
- wr_data  in  16  host pixel data.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_base  in  22  first word address of the fill.
- fill_len  in  16  number of words to fill; 0 means no-op.
- fill_color  in  16  fill value.
- fill_busy  out  1  fill engine active.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.
- sd_address  out  22  to controller address.
- sd_data  out  16  to controller i_data.
- sd_rdwr  out  1  to controller rdwr; constant 1 (write).
- sd_clk  out  1  to controller clk; one-cycle request strobe.
- sd_lock  in  1  from controller lock; 1 means busy, initialising or in the line-fetch window.

Behaviour:
- Clocking: single clock domain; all outputs are registered.
- Reset values: sd_clk=0, sd_address=0, sd_data=0, fill_busy=0, level=0, wr_ready=1 after reset. On reset the FIFO is emptied, any fill is aborted and the drain FSM returns to IDLE. A write already strobed into the controller completes there and is not tracked.
- FIFO:
  - Synchronous FIFO.
  - Push and pop in the same cycle is legal; level is unchanged.
  - Push when full never happens because wr_ready and the fill engine both gate on full.
  - Pop happens only from the drain FSM.
- wr_ready = !full & !fill_busy (combinational from registered state).
- Fill engine:
  - fill_start while fill_busy=0 and fill_len!=0 latches base/len/color and sets fill_busy next cycle.
  - fill_start while busy is ignored; fill_len=0 is ignored.
  - While busy: push {addr, color} every cycle the FIFO is not full, then addr += 1 and remaining -= 1.
  - Address wraps modulo 2^22.
  - fill_busy clears in the cycle after the last push.
  - A host write accepted in the same cycle as fill_start is pushed first; fill pushes begin the next cycle.
- Drain FSM, 3 states:
  - IDLE: if FIFO not empty and sd_lock==0, load sd_address/sd_data from the FIFO head, set sd_clk=1, go to SENT.
  - SENT: sd_clk=0, go to BUSY. sd_lock is ignored this cycle because the controller registers lock on the strobe edge.
  - BUSY: hold sd_address/sd_data stable. The controller samples the address at internal steps 0 and 3 and drives i_data onto dq during the write. When sd_lock==0, pop the FIFO head and go to IDLE.
- Latency: from FIFO non-empty with sd_lock=0 to sd_clk high is 1 cycle. Minimum spacing between consecutive sd_clk strobes is set by the controller's write time, about 10 cycles.
- Contract: the controller accepts any strobe given while lock==0. Writes are issued strictly in FIFO order.
- Boundary: if sd_lock is held high (SDRAM init, or the 5x128-word line fetch on each VGA line), IDLE waits indefinitely. The FIFO keeps accepting until full, then wr_ready=0 and the fill engine stalls.

Test Plan:
- Reset with sd_lock=0, FIFO empty -> sd_clk stays 0, wr_ready=1, level=0, fill_busy=0.
- Single host write addr=0x00012A, data=0xF800 with the controller model raising lock for 9 cycles -> sd_clk high exactly 1 cycle with sd_address=0x00012A and sd_data=0xF800. Both hold until lock falls; level goes 1 -> 0 on the pop.
- sd_lock held 1 for 100 cycles while the host pushes 20 writes (DEPTH_LOG2=4) -> wr_ready drops after 16 accepted and level=16. After lock releases, all 16 appear on sd_* in order and the remaining 4 are then accepted.
- fill_start with base=0x3FFFFE, len=4, color=0x07E0 -> strobed addresses are 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001, all with data 0x07E0. fill_busy clears after the 4th push; wr_ready=0 throughout.
- Host write and fill_start in the same cycle; fill_len=0 pulse; fill_start while busy -> the host word drains first, the zero-length fill and the busy-time fill cause no pushes, and only the original fill completes.
- Reset asserted in the BUSY state with 5 entries queued -> the next cycle has level=0, sd_clk=0 and FSM in IDLE. No further strobes occur until new writes arrive.
